// File: rtl/minisys_pkg.sv
// Shared MiniSys1A pipeline constants: datapath/register widths, writeback
// source selects and load-type encodings.
// Latency: n/a (declarations only). Backpressure: n/a.
package minisys_pkg;

   localparam int DATA_W = 32;   // datapath width
   localparam int REGN_W = 5;    // register-number width
   localparam int CNT_W  = 32;   // retire counter width

   // writeback source select (3 is reserved and behaves as ALU)
   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_MEM  = 2'd1;
   localparam logic [1:0] WB_SEL_LINK = 2'd2;

   // load types (5-7 behave as LW)
   localparam logic [2:0] LD_LW  = 3'd0;
   localparam logic [2:0] LD_LB  = 3'd1;
   localparam logic [2:0] LD_LBU = 3'd2;
   localparam logic [2:0] LD_LH  = 3'd3;
   localparam logic [2:0] LD_LHU = 3'd4;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bundle: MEM-stage result fields in, regfile write port, forwarding
// copies and the retire counter out.
// Latency: n/a (wiring only). Backpressure: none; stall/flush are plain ports.
// Ports: in_* driven by the MEM side; wn/d/we, fwd_*, instret driven by wb_stage.
interface wb_stage_if #(
   parameter int DW   = minisys_pkg::DATA_W,
   parameter int AW   = minisys_pkg::REGN_W,
   parameter int CNTW = minisys_pkg::CNT_W
);
   logic            in_valid;
   logic            in_we;
   logic [AW-1:0]   in_wn;
   logic [1:0]      in_wb_sel;
   logic [2:0]      in_ld_type;
   logic [1:0]      in_addr_lo;
   logic [DW-1:0]   in_alu_res;
   logic [DW-1:0]   in_mem_rdata;
   logic [DW-1:0]   in_pc8;

   logic [AW-1:0]   wn;
   logic [DW-1:0]   d;
   logic            we;
   logic            fwd_valid;
   logic [AW-1:0]   fwd_wn;
   logic [DW-1:0]   fwd_data;
   logic [CNTW-1:0] instret;

   // MEM stage / environment side
   modport master (
      output in_valid, in_we, in_wn, in_wb_sel, in_ld_type, in_addr_lo,
             in_alu_res, in_mem_rdata, in_pc8,
      input  wn, d, we, fwd_valid, fwd_wn, fwd_data, instret
   );

   // writeback stage side
   modport slave (
      input  in_valid, in_we, in_wn, in_wb_sel, in_ld_type, in_addr_lo,
             in_alu_res, in_mem_rdata, in_pc8,
      output wn, d, we, fwd_valid, fwd_wn, fwd_data, instret
   );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Little-endian load extraction: picks byte/halfword by address and sign/zero
// extends it. Latency: combinational. Backpressure: none.
// Ports: rdata (aligned word), addr_lo, ld_type in; ext out.
module load_ext
   import minisys_pkg::*;
#(
   parameter int DW = DATA_W
) (
   input  logic [DW-1:0] rdata,
   input  logic [1:0]    addr_lo,
   input  logic [2:0]    ld_type,
   output logic [DW-1:0] ext
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // byte lane = addr_lo, halfword lane = addr_lo[1]; addr_lo[0] ignored for halves
   assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign w_half = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      ext = rdata;
      case (ld_type)
         LD_LB:   ext = {{(DW-8){w_byte[7]}}, w_byte};
         LD_LBU:  ext = {{(DW-8){1'b0}}, w_byte};
         LD_LH:   ext = {{(DW-16){w_half[15]}}, w_half};
         LD_LHU:  ext = {{(DW-16){1'b0}}, w_half};
         default: ext = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register + writeback formatter driving the regfile port.
// Latency: 1 cycle (outputs combinational from the register). Backpressure:
// stall holds the register (write fires only in its first cycle), flush wins.
// Ports: clk, rst (sync, active-high), stall, flush; bus = wb_stage_if.slave.
module wb_stage
   import minisys_pkg::*;
#(
   parameter int DW   = DATA_W,
   parameter int AW   = REGN_W,
   parameter int CNTW = CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall,
   input  logic       flush,
   wb_stage_if.slave  bus
);

   logic            r_valid;
   logic            r_fresh;     // first cycle of this instruction in WB
   logic            r_we;
   logic [AW-1:0]   r_wn;
   logic [1:0]      r_wb_sel;
   logic [2:0]      r_ld_type;
   logic [1:0]      r_addr_lo;
   logic [DW-1:0]   r_alu_res;
   logic [DW-1:0]   r_mem_rdata;
   logic [DW-1:0]   r_pc8;
   logic [CNTW-1:0] r_instret;

   logic [DW-1:0]   w_ext;
   logic [DW-1:0]   w_d;
   logic            w_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_fresh     <= 1'b0;
         r_we        <= 1'b0;
         r_wn        <= '0;
         r_wb_sel    <= '0;
         r_ld_type   <= '0;
         r_addr_lo   <= '0;
         r_alu_res   <= '0;
         r_mem_rdata <= '0;
         r_pc8       <= '0;
         r_instret   <= '0;
      end else begin
         // retire is counted when the instruction leaves its first WB cycle,
         // whether or not it writes a GPR
         if (r_valid && r_fresh)
            r_instret <= r_instret + CNTW'(1);

         if (flush) begin
            r_valid     <= 1'b0;
            r_fresh     <= 1'b0;
            r_we        <= 1'b0;
            r_wn        <= '0;
            r_wb_sel    <= '0;
            r_ld_type   <= '0;
            r_addr_lo   <= '0;
            r_alu_res   <= '0;
            r_mem_rdata <= '0;
            r_pc8       <= '0;
         end else if (stall) begin
            r_fresh <= 1'b0;
         end else begin
            r_valid     <= bus.in_valid;
            r_fresh     <= bus.in_valid;
            r_we        <= bus.in_we;
            r_wn        <= bus.in_wn;
            r_wb_sel    <= bus.in_wb_sel;
            r_ld_type   <= bus.in_ld_type;
            r_addr_lo   <= bus.in_addr_lo;
            r_alu_res   <= bus.in_alu_res;
            r_mem_rdata <= bus.in_mem_rdata;
            r_pc8       <= bus.in_pc8;
         end
      end
   end

   load_ext #(.DW(DW)) u_load_ext (
      .rdata   (r_mem_rdata),
      .addr_lo (r_addr_lo),
      .ld_type (r_ld_type),
      .ext     (w_ext)
   );

   always_comb begin
      w_d = r_alu_res;
      case (r_wb_sel)
         WB_SEL_MEM:  w_d = w_ext;
         WB_SEL_LINK: w_d = r_pc8;
         default:     w_d = r_alu_res;
      endcase
   end

   // fresh gating makes a stalled instruction write once; r0 is never written
   assign w_we = r_valid & r_fresh & r_we & (r_wn != '0);

   assign bus.wn        = r_wn;
   assign bus.d         = w_d;
   assign bus.we        = w_we;
   assign bus.fwd_valid = w_we;
   assign bus.fwd_wn    = r_wn;
   assign bus.fwd_data  = w_d;
   assign bus.instret   = r_instret;

endmodule
